y86_mem_arbiter: RTL and testbench
==================================

Name: y86_mem_arbiter

Overview:
- Shares the single y86_seq memory bus between the CPU and a burst DMA/debug master.
- The CPU has no stall input, so it always wins the bus combinationally and is never delayed.
- The DMA master runs word bursts only in cycles where the CPU is not using the bus (the CPU touches memory only in its fetch and memory-access phases).
- Sits between the CPU bus pins and the single-port memory model.

Parameters:
- ADDR_STEP, 4, byte increment applied to the DMA address after each issued beat.
- LEN_W, 8, width of the burst length field; maximum burst is 2^LEN_W-1 beats.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_A  in  32  CPU address (connects to y86_seq bus_A).
- cpu_out  in  32  CPU write data (bus_out).
- cpu_WE  in  1  CPU write strobe.
- cpu_RE  in  1  CPU read strobe.
- cpu_in  out  32  read data to CPU (bus_in); equals mem_rdata at all times.
- dma_req  in  1  start-burst request, sampled only in IDLE.
- dma_we  in  1  burst direction: 1 = write, 0 = read; latched at start.
- dma_addr  in  32  burst start address; latched at start.
- dma_len  in  LEN_W  beat count; latched at start.
- dma_wdata  in  32  write data for the current beat.
- dma_wack  out  1  write beat issued this cycle; DMA presents the next word on the following cycle.
- dma_rdata  out  32  registered read data.
- dma_rvalid  out  1  dma_rdata valid, one-cycle pulse per read beat.
- dma_busy  out  1  high in BUSY.
- dma_done  out  1  one-cycle completion pulse.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  32  memory read data, valid in the same cycle as mem_re.

Behaviour:
- States: IDLE, BUSY.
- Reset: state=IDLE. dma_busy=0, dma_done=0, dma_rvalid=0, dma_wack=0, dma_rdata=0. Internal address and remaining-beat counters are cleared.
- cpu_act = cpu_WE | cpu_RE.
- Bus mux (combinational):
  - If cpu_act: mem_addr=cpu_A, mem_wdata=cpu_out, mem_we=cpu_WE, mem_re=cpu_RE. Both strobes pass unchanged, even if both are high.
  - Else if a DMA beat is issued: the DMA drives the bus.
  - Else: all mem_* outputs are 0.
- IDLE:
  - dma_req=1 and dma_len!=0: latch addr, we and len, then go to BUSY next cycle.
  - dma_req=1 and dma_len==0: stay IDLE and pulse dma_done next cycle.
  - No beat is issued in the request cycle.
- BUSY beat issue:
  - A beat is issued in any BUSY cycle with cpu_act=0. No beat is issued in a cycle with cpu_act=1.
  - Write beat: mem_addr=cur_addr, mem_wdata=dma_wdata, mem_we=1, dma_wack=1 combinationally in the same cycle.
  - Read beat: mem_addr=cur_addr, mem_re=1. On the next edge dma_rdata<=mem_rdata, so dma_rvalid=1 in the following cycle.
  - On each beat: cur_addr<=cur_addr+ADDR_STEP, wrapping modulo 2^32, and remaining<=remaining-1.
  - When remaining==1 at beat issue: go to IDLE. dma_done pulses in the next cycle; for reads it is coincident with the final dma_rvalid.
- dma_req asserted while BUSY is ignored. The request is not queued.
- dma_busy is high from the cycle after acceptance up to and including the last-beat cycle.
- A beat back-to-back with a new request: a new burst may be accepted in the cycle dma_done is high, since the state is IDLE.
- rst mid-burst: return to IDLE. No dma_done and no further rvalid. Any in-flight read pulse is suppressed.
- A CPU access always completes in its own cycle. The DMA simply skips that cycle; beats are never reordered or dropped.

Test Plan:
- CPU-only passthrough: cpu_RE=1, cpu_A=0x10, mem_rdata=0xDEADBEEF -> mem_re=1, mem_addr=0x10, cpu_in=0xDEADBEEF; dma_busy stays 0.
- DMA write burst on an idle CPU: dma_addr=0x100, dma_len=3, dma_we=1, wdata 0xA,0xB,0xC -> writes at 0x100, 0x104, 0x108 on 3 consecutive cycles starting 1 cycle after req, wack high each beat; dma_done 1 cycle after the third beat.
- Read burst with CPU interleave: dma_len=4 from 0x200, with cpu_RE high during beat cycle 2 -> CPU gets that cycle; DMA reads resume at 0x208. There are exactly 4 rvalid pulses with data from 0x200..0x20C in order; the burst takes 5 cycles.
- Zero-length request: dma_req with dma_len=0 -> no mem_* activity, dma_busy=0, dma_done pulses 1 cycle later.
- Address wrap: dma_addr=0xFFFFFFFC, dma_len=2 -> beats at 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: rst after 2 of 5 beats -> IDLE next cycle, all outputs 0, no dma_done; a new burst is accepted normally afterward.

Source files
------------

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: shares the y86_seq memory bus between the CPU and a
// burst DMA/debug master. The CPU always wins; DMA beats fill idle cycles.
module y86_mem_arbiter #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cpu_A,
  input  logic [31:0]      cpu_out,
  input  logic             cpu_WE,
  input  logic             cpu_RE,
  output logic [31:0]      cpu_in,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_wack,
  output logic [31:0]      dma_rdata,
  output logic             dma_rvalid,
  output logic             dma_busy,
  output logic             dma_done,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [31:0]      mem_rdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [31:0]      cur_addr;
  logic [LEN_W-1:0] remaining;
  logic             we_r;
  logic             cpu_act;
  logic             beat;

  assign cpu_act  = cpu_WE | cpu_RE;
  assign beat     = (state == BUSY) && !cpu_act;
  assign dma_busy = (state == BUSY);
  assign dma_wack = beat & we_r;
  assign cpu_in   = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (1'b1)
      cpu_act: begin
        mem_addr  = cpu_A;
        mem_wdata = cpu_out;
        mem_we    = cpu_WE;
        mem_re    = cpu_RE;
      end
      beat: begin
        mem_addr  = cur_addr;
        mem_wdata = we_r ? dma_wdata : '0;
        mem_we    = we_r;
        mem_re    = !we_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      we_r       <= 1'b0;
      dma_done   <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_done   <= 1'b0;
      dma_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dma_req) begin
            if (dma_len != '0) begin
              cur_addr  <= dma_addr;
              remaining <= dma_len;
              we_r      <= dma_we;
              state     <= BUSY;
            end else begin
              dma_done <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (beat) begin
            cur_addr  <= cur_addr + 32'(ADDR_STEP);
            remaining <= remaining - LEN_W'(1);
            if (!we_r) begin
              dma_rdata  <= mem_rdata;
              dma_rvalid <= 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
              state    <= IDLE;
              dma_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb_y86_mem_arbiter: directed vectors and burst sequences
// for the CPU/DMA memory bus arbiter.
module tb_y86_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_A;
  logic [31:0] cpu_out;
  logic        cpu_WE;
  logic        cpu_RE;
  logic [31:0] cpu_in;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [7:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_wack;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        dma_busy;
  logic        dma_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic        model_en;
  logic [31:0] drv_rdata;
  int          n_tests;
  int          n_fail;

  // memory contents are a fixed pattern of the address
  assign mem_rdata = model_en ? (mem_addr ^ 32'h5A5A_0000) : drv_rdata;

  y86_mem_arbiter #(.ADDR_STEP(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_A(cpu_A), .cpu_out(cpu_out),
    .cpu_WE(cpu_WE), .cpu_RE(cpu_RE),
    .cpu_in(cpu_in),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wack(dma_wack),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_we;
    logic        x_re;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_A     = '0;
    cpu_out   = '0;
    cpu_WE    = 1'b0;
    cpu_RE    = 1'b0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_len   = '0;
    dma_wdata = '0;
    drv_rdata = '0;
  endtask

  task automatic chk_bus(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic we,
                         input logic re);
    chk({tag, ".addr"}, mem_addr, a);
    chk({tag, ".wdata"}, mem_wdata, d);
    chk({tag, ".we"}, {31'b0, mem_we}, {31'b0, we});
    chk({tag, ".re"}, {31'b0, mem_re}, {31'b0, re});
  endtask

  vec_t vt[4];

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    model_en = 1'b0;
    idle_in();
    rst = 1'b1;

    vt[0] = '{32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF,
              32'h10, 32'h0, 1'b0, 1'b1};
    vt[1] = '{32'h20, 32'h1234, 1'b1, 1'b0, 32'h0,
              32'h20, 32'h1234, 1'b1, 1'b0};
    vt[2] = '{32'h30, 32'h55, 1'b1, 1'b1, 32'h77,
              32'h30, 32'h55, 1'b1, 1'b1};
    vt[3] = '{32'h40, 32'h77, 1'b0, 1'b0, 32'h99,
              32'h0, 32'h0, 1'b0, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk("rst.busy", {31'b0, dma_busy}, 32'h0);
    chk("rst.done", {31'b0, dma_done}, 32'h0);
    chk("rst.rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("rst.wack", {31'b0, dma_wack}, 32'h0);
    chk("rst.rdata", dma_rdata, 32'h0);
    chk_bus("rst", 32'h0, 32'h0, 1'b0, 1'b0);

    // CPU passthrough vectors
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_A     = vt[i].a;
      cpu_out   = vt[i].d;
      cpu_WE    = vt[i].we;
      cpu_RE    = vt[i].re;
      drv_rdata = vt[i].rd;
      #1;
      chk_bus($sformatf("vec%0d", i), vt[i].x_addr,
              vt[i].x_wdata, vt[i].x_we, vt[i].x_re);
      chk($sformatf("vec%0d.cpu_in", i), cpu_in, vt[i].rd);
      chk($sformatf("vec%0d.busy", i),
          {31'b0, dma_busy}, 32'h0);
    end

    // write burst of 3 on idle CPU
    tick();
    idle_in();
    dma_req  = 1'b1;
    dma_we   = 1'b1;
    dma_addr = 32'h100;
    dma_len  = 8'd3;
    #1;
    chk_bus("wr.req", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("wr.req.wack", {31'b0, dma_wack}, 32'h0);
    for (int b = 0; b < 3; b++) begin
      tick();
      dma_req   = 1'b0;
      dma_wdata = 32'hA + 32'(b);
      #1;
      chk_bus($sformatf("wr.b%0d", b), 32'h100 + 32'(4 * b),
              32'hA + 32'(b), 1'b1, 1'b0);
      chk($sformatf("wr.b%0d.wack", b), {31'b0, dma_wack}, 32'h1);
      chk($sformatf("wr.b%0d.busy", b), {31'b0, dma_busy}, 32'h1);
      chk($sformatf("wr.b%0d.done", b), {31'b0, dma_done}, 32'h0);
    end
    tick();
    dma_wdata = '0;
    #1;
    chk("wr.done", {31'b0, dma_done}, 32'h1);
    chk("wr.busy_end", {31'b0, dma_busy}, 32'h0);
    chk_bus("wr.end", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("wr.done_clr", {31'b0, dma_done}, 32'h0);

    // read burst of 4 with CPU read stealing one cycle
    model_en = 1'b1;
    idle_in();
    dma_req  = 1'b1;
    dma_addr = 32'h200;
    dma_len  = 8'd4;
    begin
      logic [31:0] x_addr[6];
      logic        x_re[6];
      logic        x_rv[6];
      logic [31:0] x_rd[6];
      logic        x_done[6];
      logic        x_busy[6];
      int          rv_cnt;
      x_addr = '{32'h200, 32'h204, 32'h50, 32'h208, 32'h20C, 32'h0};
      x_re   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      x_rv   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      x_rd   = '{32'h0, 32'h5A5A0200, 32'h5A5A0204, 32'h0,
                 32'h5A5A0208, 32'h5A5A020C};
      x_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      x_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rv_cnt = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        dma_req = 1'b0;
        cpu_RE  = (c == 2);
        cpu_A   = (c == 2) ? 32'h50 : 32'h0;
        #1;
        chk($sformatf("rd.c%0d.addr", c), mem_addr, x_addr[c]);
        chk($sformatf("rd.c%0d.re", c),
            {31'b0, mem_re}, {31'b0, x_re[c]});
        chk($sformatf("rd.c%0d.rvalid", c),
            {31'b0, dma_rvalid}, {31'b0, x_rv[c]});
        if (x_rv[c])
          chk($sformatf("rd.c%0d.rdata", c), dma_rdata, x_rd[c]);
        chk($sformatf("rd.c%0d.done", c),
            {31'b0, dma_done}, {31'b0, x_done[c]});
        chk($sformatf("rd.c%0d.busy", c),
            {31'b0, dma_busy}, {31'b0, x_busy[c]});
        if (dma_rvalid) rv_cnt++;
      end
      chk("rd.cpu_in", 32'(rv_cnt), 32'd4);
    end
    model_en = 1'b0;
    idle_in();

    // zero-length request
    tick();
    dma_req = 1'b1;
    dma_len = 8'd0;
    dma_addr = 32'h700;
    #1;
    chk_bus("z.req", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    dma_req = 1'b0;
    #1;
    chk("z.done", {31'b0, dma_done}, 32'h1);
    chk("z.busy", {31'b0, dma_busy}, 32'h0);
    chk_bus("z.after", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("z.done_clr", {31'b0, dma_done}, 32'h0);

    // address wrap
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 32'hFFFF_FFFC;
    dma_len   = 8'd2;
    tick();
    dma_req   = 1'b0;
    dma_wdata = 32'h1111;
    #1;
    chk_bus("wrap.b0", 32'hFFFF_FFFC, 32'h1111, 1'b1, 1'b0);
    tick();
    dma_wdata = 32'h2222;
    #1;
    chk_bus("wrap.b1", 32'h0, 32'h2222, 1'b1, 1'b0);
    tick();
    chk("wrap.done", {31'b0, dma_done}, 32'h1);
    idle_in();

    // reset after 2 of 5 read beats
    model_en = 1'b1;
    tick();
    dma_req  = 1'b1;
    dma_addr = 32'h300;
    dma_len  = 8'd5;
    tick();
    dma_req = 1'b0;
    #1;
    chk("rr.b0.addr", mem_addr, 32'h300);
    tick();
    chk("rr.b1.addr", mem_addr, 32'h304);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rr.busy", {31'b0, dma_busy}, 32'h0);
    chk("rr.rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("rr.done", {31'b0, dma_done}, 32'h0);
    chk("rr.rdata", dma_rdata, 32'h0);
    chk_bus("rr", 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("rr.done2", {31'b0, dma_done}, 32'h0);
    chk("rr.busy2", {31'b0, dma_busy}, 32'h0);
    model_en = 1'b0;

    // fresh single-beat write after reset
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 32'h400;
    dma_len   = 8'd1;
    tick();
    dma_req   = 1'b0;
    dma_wdata = 32'hCAFE;
    #1;
    chk_bus("nb", 32'h400, 32'hCAFE, 1'b1, 1'b0);
    chk("nb.wack", {31'b0, dma_wack}, 32'h1);
    tick();
    chk("nb.done", {31'b0, dma_done}, 32'h1);
    chk("nb.busy", {31'b0, dma_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
